// File: rtl/rename_map_table_pkg.sv
// Shared core defines for the rename map table: widths, map entry type and reset map.
package rename_map_table_pkg;

   localparam int unsigned FETCH_WIDTH  = 4;
   localparam int unsigned COMMIT_WIDTH = 4;
   localparam int unsigned AREG_NUM     = 32;
   localparam int unsigned AREG_WIDTH   = 5;
   localparam int unsigned PREG_SIZE    = 128;
   localparam int unsigned PREG_WIDTH   = $clog2(PREG_SIZE);

   typedef logic [PREG_WIDTH-1:0] map_entry_t;
   typedef logic [AREG_WIDTH-1:0] areg_t;
   typedef map_entry_t [AREG_NUM-1:0] map_table_t;

   // areg i maps to preg i, leaving pregs AREG_NUM.. in the freelist
   function automatic map_table_t identity_map();
      map_table_t m;
      for (int i = 0; i < AREG_NUM; i++) begin
         m[i] = map_entry_t'(i);
      end
      return m;
   endfunction

endpackage

// File: rtl/map_bypass.sv
// Priority last-match search: each slot takes the value of the youngest older slot
// writing the same key, otherwise its table read.
module map_bypass
   import rename_map_table_pkg::*;
#(
   parameter int unsigned NumSlots = 4
) (
   input  logic [NumSlots-1:0][AREG_WIDTH-1:0] key_i,
   input  logic [NumSlots-1:0][PREG_WIDTH-1:0] base_i,
   input  logic [NumSlots-1:0]                 wr_valid_i,
   input  logic [NumSlots-1:0][AREG_WIDTH-1:0] wr_key_i,
   input  logic [NumSlots-1:0][PREG_WIDTH-1:0] wr_val_i,
   output logic [NumSlots-1:0][PREG_WIDTH-1:0] res_o
);

   // Ascending scan so the highest matching older slot is the one that sticks.
   always_comb begin
      for (int i = 0; i < NumSlots; i++) begin
         res_o[i] = base_i[i];
         for (int j = 0; j < NumSlots; j++) begin
            if (j < i && wr_valid_i[j] && (wr_key_i[j] == key_i[i])) begin
               res_o[i] = wr_val_i[j];
            end
         end
      end
   end

endmodule

// File: rtl/rename_map_table.sv
// Speculative and architectural register map tables with intra-group bypass,
// commit-time freeing and single-cycle redirect restore.
module rename_map_table
   import rename_map_table_pkg::*;
(
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [FETCH_WIDTH-1:0]                  ren_en,
   input  logic [FETCH_WIDTH-1:0]                  ren_we,
   input  logic [FETCH_WIDTH-1:0][AREG_WIDTH-1:0]  ren_rs1,
   input  logic [FETCH_WIDTH-1:0][AREG_WIDTH-1:0]  ren_rs2,
   input  logic [FETCH_WIDTH-1:0][AREG_WIDTH-1:0]  ren_rd,
   input  logic [FETCH_WIDTH-1:0][PREG_WIDTH-1:0]  ren_prd,
   input  logic                                    stall,
   output logic [FETCH_WIDTH-1:0][PREG_WIDTH-1:0]  prs1,
   output logic [FETCH_WIDTH-1:0][PREG_WIDTH-1:0]  prs2,
   output logic [FETCH_WIDTH-1:0][PREG_WIDTH-1:0]  old_prd,
   input  logic [COMMIT_WIDTH-1:0]                 cmt_en,
   input  logic [COMMIT_WIDTH-1:0]                 cmt_we,
   input  logic [COMMIT_WIDTH-1:0][AREG_WIDTH-1:0] cmt_rd,
   input  logic [COMMIT_WIDTH-1:0][PREG_WIDTH-1:0] cmt_prd,
   output logic [COMMIT_WIDTH-1:0]                 free_en,
   output logic [COMMIT_WIDTH-1:0][PREG_WIDTH-1:0] free_prd,
   input  logic                                    redirect
);

   map_table_t spec_q, spec_d;
   map_table_t arch_q, arch_d;

   logic [FETCH_WIDTH-1:0]                  ren_valid;
   logic [COMMIT_WIDTH-1:0]                 cmt_valid;
   logic [FETCH_WIDTH-1:0][PREG_WIDTH-1:0]  rs1_base, rs2_base, rd_base;
   logic [COMMIT_WIDTH-1:0][PREG_WIDTH-1:0] cmt_base;

   // A destination of x0 counts as no write, which keeps entry 0 pinned at 0.
   always_comb begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         ren_valid[i] = ren_en[i] & ren_we[i] & (ren_rd[i] != '0);
         rs1_base[i]  = spec_q[ren_rs1[i]];
         rs2_base[i]  = spec_q[ren_rs2[i]];
         rd_base[i]   = spec_q[ren_rd[i]];
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         cmt_valid[k] = cmt_en[k] & cmt_we[k] & (cmt_rd[k] != '0);
         cmt_base[k]  = arch_q[cmt_rd[k]];
      end
   end

   assign free_en = cmt_valid;

   map_bypass #(.NumSlots(FETCH_WIDTH)) u_bypass_prs1 (
      .key_i      (ren_rs1),
      .base_i     (rs1_base),
      .wr_valid_i (ren_valid),
      .wr_key_i   (ren_rd),
      .wr_val_i   (ren_prd),
      .res_o      (prs1)
   );

   map_bypass #(.NumSlots(FETCH_WIDTH)) u_bypass_prs2 (
      .key_i      (ren_rs2),
      .base_i     (rs2_base),
      .wr_valid_i (ren_valid),
      .wr_key_i   (ren_rd),
      .wr_val_i   (ren_prd),
      .res_o      (prs2)
   );

   map_bypass #(.NumSlots(FETCH_WIDTH)) u_bypass_old_prd (
      .key_i      (ren_rd),
      .base_i     (rd_base),
      .wr_valid_i (ren_valid),
      .wr_key_i   (ren_rd),
      .wr_val_i   (ren_prd),
      .res_o      (old_prd)
   );

   map_bypass #(.NumSlots(COMMIT_WIDTH)) u_bypass_free_prd (
      .key_i      (cmt_rd),
      .base_i     (cmt_base),
      .wr_valid_i (cmt_valid),
      .wr_key_i   (cmt_rd),
      .wr_val_i   (cmt_prd),
      .res_o      (free_prd)
   );

   // Redirect restores from arch_d so the same cycle's commits are included.
   always_comb begin
      arch_d = arch_q;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         if (cmt_valid[k]) begin
            arch_d[cmt_rd[k]] = cmt_prd[k];
         end
      end
      spec_d = spec_q;
      if (redirect) begin
         spec_d = arch_d;
      end else if (!stall) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (ren_valid[i]) begin
               spec_d[ren_rd[i]] = ren_prd[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spec_q <= identity_map();
         arch_q <= identity_map();
      end else begin
         spec_q <= spec_d;
         arch_q <= arch_d;
      end
   end

endmodule

// File: doc/rename_map_table.md
RENAME_MAP_TABLE -- requirements
Module: rename_map_table

Interface
REQ-001 Parameters (shared package): FETCH_WIDTH=4 rename slots; COMMIT_WIDTH=4 commit slots; AREG_NUM=32; AREG_WIDTH=5; PREG_SIZE=128; PREG_WIDTH=7.
REQ-002 Ports; clock and reset come first.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ren_en  in  FETCH_WIDTH  rename slot valid.
- ren_we  in  FETCH_WIDTH  slot writes a destination.
- ren_rs1, ren_rs2, ren_rd  in  FETCH_WIDTH x AREG_WIDTH  architectural sources and destination.
- ren_prd  in  FETCH_WIDTH x PREG_WIDTH  new physical destinations from the freelist.
- stall  in  1  rename group not accepted this cycle.
- prs1, prs2  out  FETCH_WIDTH x PREG_WIDTH  renamed sources.
- old_prd  out  FETCH_WIDTH x PREG_WIDTH  previous mapping of ren_rd.
- cmt_en, cmt_we  in  COMMIT_WIDTH  commit slot valid / writes a destination.
- cmt_rd  in  COMMIT_WIDTH x AREG_WIDTH  committed destination.
- cmt_prd  in  COMMIT_WIDTH x PREG_WIDTH  committed physical destination.
- free_en  out  COMMIT_WIDTH  slot releases a physical register.
- free_prd  out  COMMIT_WIDTH x PREG_WIDTH  physical register released to the freelist.
- redirect  in  1  pipeline flush; restore the speculative map.

Function
REQ-003 The block holds two tables: the speculative table (spec) and the architectural table (arch). Each table has AREG_NUM entries of PREG_WIDTH.
REQ-004 prs1, prs2 and old_prd are combinational reads of spec, with intra-group bypass applied.
REQ-005 Source bypass: prs1[i] is the ren_prd of the highest j<i with ren_en[j], ren_we[j] and ren_rd[j]==ren_rs1[i]. If no such j exists, prs1[i] is the spec entry. prs2 follows the same rule.
REQ-006 WAW bypass: old_prd[i] is the ren_prd of the highest j<i with ren_en[j], ren_we[j] and ren_rd[j]==ren_rd[i]. If no such j exists, old_prd[i] is the spec entry.
REQ-007 Spec update: when !stall and !redirect, each slot with ren_en and ren_we writes spec[ren_rd] <= ren_prd at the next edge. On a same-rd conflict, the highest slot wins.
REQ-008 Destination x0: ren_rd==0 and cmt_rd==0 are treated as we=0. Entry 0 of both tables stays 0 permanently.
REQ-009 Source x0: a source of 0 yields 0 and never bypasses.
REQ-010 free_en[k] = cmt_en[k] & cmt_we[k] & (cmt_rd[k]!=0). This is combinational, in the same cycle as the commit.
REQ-011 free_prd[k] is the cmt_prd of the highest m<k with a valid same-rd commit. If no such m exists, free_prd[k] is arch[cmt_rd[k]]. This is the old architectural mapping.
REQ-012 Arch update: each valid commit slot writes arch[cmt_rd] <= cmt_prd at the next edge. On a same-rd conflict, the highest slot wins. Commits are never blocked by stall or redirect.
REQ-013 Redirect is asserted only at commit time, when no older uncommitted instruction remains. On redirect, spec <= arch at the next edge.
REQ-014 The restored arch includes that cycle's commits, via the same bypass as REQ-012.
REQ-015 A rename group presented in the redirect cycle is discarded.
REQ-016 Spec is usable in the cycle after redirect; no extra recovery cycle exists.
REQ-017 While stall is high, spec is held and the outputs keep tracking the inputs combinationally.
REQ-018 Simultaneous rename and commit to the same areg: spec and arch update independently. No cross bypass exists between the two tables.

Reset
REQ-019 On rst at a rising edge, spec[i] <= i and arch[i] <= i for i=0..31. This is consistent with the freelist initially holding pregs 32..127.
REQ-020 rst overrides redirect, rename and commit in the same cycle. rst asserted mid-group discards that group.
REQ-021 Outputs are combinational. During reset they reflect the inputs against the identity map.

Structure
REQ-022 FETCH_WIDTH, COMMIT_WIDTH, AREG_NUM, AREG_WIDTH, PREG_WIDTH and a map_entry_t typedef belong in the shared core defines package. No local redefinition is permitted.
REQ-023 One sub-module, map_bypass, implements the priority last-match search. It is instantiated for the prs1, prs2, old_prd and free_prd paths.
REQ-024 Tables are flip-flop arrays. No SRAM is used; a single-cycle restore is required.

Verification
REQ-025 Reset, then rename slot0 rd=5 prd=40, rs1=5 -> prs1=5, old_prd=5. Next cycle, rs1=5 reads 40.
REQ-026 Group with slot0 rd=3 prd=33, slot1 rd=3 prd=34, slot2 rs1=3 rs2=3 -> slot1 old_prd=33; slot2 prs1=prs2=34. spec[3]=34 afterwards.
REQ-027 stall=1 with valid rd=7 prd=50 -> spec[7] stays 7. Deassert stall -> spec[7]=50 next cycle.
REQ-028 Commit slot0 rd=4 prd=36 and slot1 rd=4 prd=37 from reset -> free_prd0=4, free_prd1=36. arch[4]=37 afterwards.
REQ-029 Rename rd=6 prd=60 (spec), commit nothing, then redirect with a concurrent commit rd=9 prd=45 -> next cycle spec[6]=6, spec[9]=45. A rename group in the redirect cycle leaves no trace.
REQ-030 rd=0 with prd=99 on rename and commit -> free_en=0; spec[0]=arch[0]=0; rs1=0 gives prs1=0.
